wavetable_reader: RTL
=====================

WAVETABLE_READER -- requirements
Module: wavetable_reader

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the number of cycles to wait for mem_done before the memory transaction is abandoned.
REQ-002 The block SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port en  input  1  playback enable.
REQ-005 The block SHALL have port tick  input  1  one-cycle sample-rate strobe.
REQ-006 The block SHALL have port phase_inc  input  24  phase increment per sample.
REQ-007 The block SHALL have port base  input  15  table base word address.
REQ-008 The block SHALL have port ld_req  input  1  host table-load request, level, held until ld_ack.
REQ-009 The block SHALL have ports ld_addr (input, 10, table word offset) and ld_data (input, 16, word to load).
REQ-010 The block SHALL have port ld_ack  output  1  one-cycle pulse when the load write completes.
REQ-011 The block SHALL have ports A (output, 15, memory address), Din (output, 16, write data), RD (output, 1, read strobe) and WR (output, 1, write strobe) toward the memory controller.
REQ-012 The block SHALL have ports mem_q (input, 16, read data) and mem_done (input, 1, completion pulse) from the memory controller.
REQ-013 The block SHALL have ports sample (output, 16, current sample), sample_valid (output, 1, one-cycle strobe), busy (output, 1, transaction in flight), overrun (output, 1, sticky) and timeout_err (output, 1, sticky).

Function
REQ-014 The FSM SHALL have states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT; IDLE is the reset state.
REQ-015 Phase: phase_acc SHALL be a 24-bit accumulator; table index = phase_acc[23:14]; read address = base + {5'b0, index}, 15-bit, wrapping modulo 2^15.
REQ-016 Tick capture: a tick while en=1 SHALL set pending; a tick while pending is already set, or while a read is in flight, SHALL set overrun, and the extra tick SHALL be dropped (at most one pending tick).
REQ-017 IDLE arbitration: pending SHALL take priority over ld_req; pending -> RD_REQ; else ld_req -> WR_REQ; else stay in IDLE.
REQ-018 RD_REQ SHALL drive RD=1 for exactly one cycle with A = read address, clear pending, and go to RD_WAIT.
REQ-019 RD_WAIT: on mem_done=1, sample SHALL be loaded with mem_q, sample_valid SHALL pulse on the next cycle, phase_acc SHALL be updated to phase_acc+phase_inc (mod 2^24), and the FSM SHALL return to IDLE.
REQ-020 WR_REQ SHALL drive WR=1 for exactly one cycle with A = base + ld_addr and Din = ld_data, then go to WR_WAIT.
REQ-021 WR_WAIT: on mem_done=1, ld_ack SHALL pulse one cycle and the FSM SHALL return to IDLE.
REQ-022 A and Din SHALL be held stable from the strobe cycle until the wait state exits.
REQ-023 RD and WR SHALL never be asserted in the same cycle, and SHALL never be reasserted before the prior mem_done or timeout.
REQ-024 Timeout: a wait-state counter SHALL start at 0 on wait entry; if it reaches TIMEOUT-1 without mem_done, the FSM SHALL set timeout_err and go to IDLE.
REQ-025 Timeout on a read: sample SHALL be unchanged, sample_valid SHALL be asserted, and phase SHALL still advance.
REQ-026 Timeout on a write: ld_ack SHALL NOT be asserted; the host request stays pending and is retried.
REQ-027 mem_done SHALL be ignored outside the wait states.
REQ-028 A mem_done arriving in the same cycle the counter reaches TIMEOUT-1 SHALL count as completion, not timeout.
REQ-029 en=0 SHALL clear pending and phase_acc to 0 and ignore ticks; an in-flight read SHALL complete normally without advancing phase; table loads SHALL remain serviced.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 overrun and timeout_err SHALL clear only on reset.

Reset
REQ-032 While rst_n=0, the block SHALL asynchronously force state=IDLE and RD=WR=0, clear A, Din, sample, phase_acc, pending, sample_valid, ld_ack, overrun and timeout_err to 0, and clear the wait counter.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction; a late mem_done after reset release SHALL be ignored.
REQ-034 The first action after reset release SHALL occur no earlier than the first rising clk edge with rst_n=1.

Verification
REQ-035 Bench: base=0x0100, phase_inc=0x004000, memory model returns word=address, mem_done 3 cycles after RD, ticks every 20 cycles -> A = 0x0100, 0x0101, 0x0102; sample = 0x0100, 0x0101, 0x0102.
REQ-036 Bench: phase_acc=0xFFC000, phase_inc=0x004000, base=0x7FFF -> index 0x3FF, A=0x03FE (15-bit wrap); next read index=0, A=0x7FFF.
REQ-037 Bench: ld_req with ld_addr=0x005, ld_data=0xBEEF coincident with tick -> RD issued first, WR to base+5 with Din=0xBEEF next, then one ld_ack pulse.
REQ-038 Bench: two ticks 2 cycles apart while a read is in flight -> overrun=1, exactly one further read issued.
REQ-039 Bench: memory never returns mem_done -> timeout_err=1 after 16 wait cycles, sample unchanged, sample_valid pulses, FSM in IDLE.
REQ-040 Bench: rst_n low during RD_WAIT, mem_done arriving 1 cycle after release -> all outputs 0, no sample_valid.

Source files
------------

// File: rtl/wavetable_reader.sv
// wavetable_reader: phase-accumulator wavetable reader that shares one memory port with host table loads.
// Reads are paced by sample ticks; host writes fill the gaps; every transaction is bounded by a timeout.
module wavetable_reader #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        tick,
  input  logic [23:0] phase_inc,
  input  logic [14:0] base,
  input  logic        ld_req,
  input  logic [9:0]  ld_addr,
  input  logic [15:0] ld_data,
  output logic        ld_ack,
  output logic [14:0] A,
  output logic [15:0] Din,
  output logic        RD,
  output logic        WR,
  input  logic [15:0] mem_q,
  input  logic        mem_done,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err
);
  localparam logic [2:0] IDLE = 3'd0, RD_REQ = 3'd1, RD_WAIT = 3'd2, WR_REQ = 3'd3, WR_WAIT = 3'd4;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [2:0] state, state_n;
  logic [23:0] phase_acc;
  logic [CW-1:0] cnt;
  logic pending, waiting, expired, finish, rd_go, wr_go, rd_fin;
  // A tick arriving in IDLE is served at once so it wins over a coincident load;
  // ld_ack masks ld_req for the one cycle the host needs to drop it.
  always_comb begin
    waiting = state == RD_WAIT || state == WR_WAIT;
    expired = waiting && !mem_done && cnt == CW'(TIMEOUT - 1);
    finish  = waiting && (mem_done || expired);
    rd_go   = state == IDLE && en && (pending || tick);
    wr_go   = state == IDLE && !rd_go && ld_req && !ld_ack;
    rd_fin  = state == RD_WAIT && finish;
    state_n = rd_go ? RD_REQ :
              wr_go ? WR_REQ :
              state == RD_REQ ? RD_WAIT :
              state == WR_REQ ? WR_WAIT :
              (finish || state > WR_WAIT) ? IDLE : state;
  end
  assign RD   = state == RD_REQ;
  assign WR   = state == WR_REQ;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      phase_acc    <= '0;
      pending      <= 1'b0;
      A            <= '0;
      Din          <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      ld_ack       <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= (waiting && !finish) ? cnt + 1'b1 : '0;
      pending      <= en && !rd_go && (tick || pending);
      overrun      <= overrun || (en && tick && (pending || state == RD_REQ || state == RD_WAIT));
      timeout_err  <= timeout_err || expired;
      sample_valid <= rd_fin;
      ld_ack       <= state == WR_WAIT && mem_done;
      phase_acc    <= !en ? '0 : rd_fin ? phase_acc + phase_inc : phase_acc;
      if (state == RD_WAIT && mem_done)
        sample <= mem_q;
      if (rd_go)
        A <= base + {5'd0, phase_acc[23:14]};
      if (wr_go) begin
        A   <= base + {5'd0, ld_addr};
        Din <= ld_data;
      end
    end
  end
endmodule
